// File: rtl/dac_serializer_pkg.sv
// Shared types and default geometry for the serial DAC transmitter.
package dac_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int CLK_DIV_DEF = 4;

endpackage

// File: rtl/dac_serializer_16b_sclk_divider.sv
// Bit-clock generator: sclk toggles every CLK_DIV clk cycles while enabled.
module sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick,
  output logic sclk
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;

  // tick ignores clear so the parent can use it to decide whether to clear
  assign tick = en && (div_cnt_q == DIV_LAST);
  assign sclk = sclk_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    if (clear) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (tick) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end else if (en) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule

// File: rtl/dac_serializer_16b.sv
// Parallel-to-serial PCM transmitter: MSB-first on sclk, ws alternates per word.
module dac_serializer_16b
  import dac_serializer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              sclk,
  output logic              ws,
  output logic              sdata,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              ws_q, ws_d;
  logic              sdata_q, sdata_d;

  logic tick;
  logic word_end;
  logic accept;
  logic div_en;
  logic div_clear;

  // Last half-period of the last bit is the only ready window inside a word
  assign word_end  = (state_q == SHIFT) && (bit_cnt_q == '0) && sclk && tick;
  assign in_rdy    = (state_q == IDLE) || word_end;
  assign accept    = in_val && in_rdy;
  assign div_en    = (state_q == SHIFT);
  assign div_clear = (state_q == IDLE) || word_end;

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (div_en),
    .clear (div_clear),
    .tick  (tick),
    .sclk  (sclk)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ws_d      = ws_q;
    sdata_d   = sdata_q;
    if (accept) begin
      state_d   = SHIFT;
      shreg_d   = in_data;
      bit_cnt_d = BW'(DATA_W - 1);
      ws_d      = ~ws_q;
      sdata_d   = in_data[DATA_W-1];
    end else if (word_end) begin
      state_d = IDLE;
      sdata_d = 1'b0;
    end else if ((state_q == SHIFT) && tick && sclk && (bit_cnt_q != '0)) begin
      // falling sclk edge: present the next bit half a period before the DAC samples
      shreg_d   = shreg_q << 1;
      sdata_d   = shreg_q[DATA_W-2];
      bit_cnt_d = bit_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ws_q      <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ws_q      <= ws_d;
      sdata_q   <= sdata_d;
    end
  end

  assign ws    = ws_q;
  assign sdata = sdata_q;
  assign busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_dac_serializer_16b.sv
// Directed bench for dac_serializer_16b: bit scoreboard per instance, CLK_DIV=4 and CLK_DIV=2.
module tb_dac_serializer_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valA = 1'b0, in_valB = 1'b0;
  logic [15:0] in_dataA = '0, in_dataB = '0;
  logic        in_rdyA, sclkA, wsA, sdataA, busyA;
  logic        in_rdyB, sclkB, wsB, sdataB, busyB;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [1:0] qA[$];
  logic [1:0] qB[$];
  logic       wsA_exp = 1'b0, wsB_exp = 1'b0;
  int         acc_cyc = 0;

  dac_serializer_16b #(.DATA_W(16), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .in_val(in_valA), .in_rdy(in_rdyA), .in_data(in_dataA),
    .sclk(sclkA), .ws(wsA), .sdata(sdataA), .busy(busyA)
  );

  dac_serializer_16b #(.DATA_W(16), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .in_val(in_valB), .in_rdy(in_rdyB), .in_data(in_dataB),
    .sclk(sclkB), .ws(wsB), .sdata(sdataB), .busy(busyB)
  );

  always #8 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: sample at the negedge following each sclk rise
  logic sclkA_prev = 1'b0, sclkB_prev = 1'b0;
  int   lastA = 0, lastB = 0;
  logic lastA_v = 1'b0, lastB_v = 1'b0;

  always @(negedge clk) begin
    if (sclkA && !sclkA_prev) begin
      chk("A_bit_expected", 32'(qA.size() != 0), 32'd1);
      if (qA.size() != 0) chk("A_ws_bit", {30'd0, wsA, sdataA}, {30'd0, qA.pop_front()});
      if (lastA_v) chk("A_sclk_period", cyc - lastA, 8);
      lastA   = cyc;
      lastA_v = 1'b1;
    end
    if (!busyA) lastA_v = 1'b0;
    sclkA_prev = sclkA;
  end

  always @(negedge clk) begin
    if (sclkB && !sclkB_prev) begin
      chk("B_bit_expected", 32'(qB.size() != 0), 32'd1);
      if (qB.size() != 0) chk("B_ws_bit", {30'd0, wsB, sdataB}, {30'd0, qB.pop_front()});
      if (lastB_v) chk("B_sclk_period", cyc - lastB, 4);
      lastB   = cyc;
      lastB_v = 1'b1;
    end
    if (!busyB) lastB_v = 1'b0;
    sclkB_prev = sclkB;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] d);
    wsA_exp = ~wsA_exp;
    for (int i = 15; i >= 0; i--) qA.push_back({wsA_exp, d[i]});
  endtask

  task automatic push_b(input logic [15:0] d);
    wsB_exp = ~wsB_exp;
    for (int i = 15; i >= 0; i--) qB.push_back({wsB_exp, d[i]});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_a(input logic [15:0] d, input logic hold);
    int t = 0;
    in_valA  = 1'b1;
    in_dataA = d;
    push_a(d);
    @(negedge clk);
    while (in_rdyA !== 1'b1 && t < 400) begin
      t++;
      @(negedge clk);
    end
    chk("A_accept_in_time", 32'(t < 400), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) in_valA = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int exp_len);
    int n = 0;
    @(negedge clk);
    while (busyA === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp_len);
  endtask

  task automatic do_reset();
    align();
    rst = 1'b0;
    wsA_exp = 1'b0;
    wsB_exp = 1'b0;
    qA.delete();
    qB.delete();
    align();
    rst = 1'b1;
  endtask

  initial begin
    int c1;
    int t;

    // 1. reset hold
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_A_outputs", {27'd0, sclkA, wsA, sdataA, busyA, in_rdyA}, 32'b00001);
      chk("rst_B_outputs", {27'd0, sclkB, wsB, sdataB, busyB, in_rdyB}, 32'b00001);
    end
    align();
    rst = 1'b1;

    // 2. single word, then idle
    align();
    send_a(16'hA5F0, 1'b0);
    wait_idle_a("A5F0_word_len", 128);
    chk("A5F0_idle_outputs", {27'd0, sclkA, wsA, sdataA, busyA, in_rdyA}, 32'b01001);

    // 3. back-to-back stream
    do_reset();
    send_a(16'h8001, 1'b1);
    c1 = acc_cyc;
    send_a(16'h7FFE, 1'b0);
    chk("stream_accept_spacing", acc_cyc - c1, 128);
    @(negedge clk);
    chk("stream_rdy_pulse_1cyc", {31'd0, in_rdyA}, 32'd0);
    wait_idle_a("stream_word2_len", 127);

    // 4. in_data changes mid-word
    align();
    send_a(16'h0000, 1'b0);
    repeat (40) @(negedge clk);
    in_dataA = 16'hFFFF;
    wait_idle_a("hold_word_len", 88);

    // 5. reset mid-word
    align();
    send_a(16'hFFFF, 1'b0);
    t = 0;
    while (qA.size() > 8 && t < 500) begin
      t++;
      @(negedge clk);
    end
    chk("abort_reached_bit7", 32'(qA.size()), 32'd8);
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, sclkA, wsA, sdataA, busyA, in_rdyA}, 32'b00001);
    qA.delete();
    wsA_exp = 1'b0;
    wsB_exp = 1'b0;
    align();
    rst = 1'b1;
    align();
    send_a(16'h0001, 1'b0);
    wait_idle_a("post_abort_word_len", 128);

    // 6. CLK_DIV=2 instance
    align();
    in_valB  = 1'b1;
    in_dataB = 16'h1234;
    push_b(16'h1234);
    @(negedge clk);
    chk("B_rdy_idle", {31'd0, in_rdyB}, 32'd1);
    align();
    in_valB = 1'b0;
    t = 0;
    @(negedge clk);
    while (busyB === 1'b1 && t < 1000) begin
      t++;
      @(negedge clk);
    end
    chk("B_word_len", t, 64);

    repeat (4) @(negedge clk);
    chk("A_queue_drained", 32'(qA.size()), 32'd0);
    chk("B_queue_drained", 32'(qB.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
